// File: rtl/tx_packet_scheduler.sv
// tx_packet_scheduler: queues USB TX packet commands from the AHB slave and
// sequences each one through buffer-fill wait, TX launch and completion.
// Optional: define TX_SCHED_STATS_EN to add saturating pkt_count/err_count.
module tx_packet_scheduler #(
  parameter int QDEPTH      = 4,
  parameter int BUF_BYTES   = 64,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  input  logic [2:0] cmd_pid,
  input  logic [6:0] cmd_len,
  output logic       cmd_ready,
  input  logic [6:0] buffer_occupancy,
  input  logic       tx_transfer_active,
  input  logic       tx_error,
  output logic       tx_start,
  output logic [2:0] tx_packet,
  output logic       flush_req,
  output logic       busy,
  output logic       done_pulse,
  output logic       err_pulse,
  output logic [1:0] err_code,
`ifdef TX_SCHED_STATS_EN
  output logic [15:0] pkt_count,
  output logic [7:0]  err_count,
`endif
  output logic [2:0] q_count
);

  localparam int AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = $clog2(QDEPTH + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_CHECK    = 3'd1;
  localparam logic [2:0] S_LAUNCH   = 3'd2;
  localparam logic [2:0] S_WAIT_ACT = 3'd3;
  localparam logic [2:0] S_ACTIVE   = 3'd4;
  localparam logic [2:0] S_DONE     = 3'd5;
  localparam logic [2:0] S_ERROR    = 3'd6;

  typedef struct packed {
    logic [2:0] pid;
    logic [6:0] len;
  } cmd_t;

  cmd_t          q_mem [QDEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt;
  logic [2:0]    state, state_n;
  logic [TW-1:0] tmo;
  logic          tmo_hit;
  logic [1:0]    fsm_code;
  cmd_t          cur;
  logic          cur_is_data;
  logic          txe_flag;
  logic          inv_q;
  logic          cmd_is_data, cmd_bad, cmd_acc, push, pop;

  // Command decode: reserved pids and oversize DATA payloads are rejected
  always_comb begin
    cmd_is_data = (cmd_pid == 3'd1) || (cmd_pid == 3'd2);
    cmd_bad     = (cmd_pid == 3'd0) || (cmd_pid >= 3'd6) ||
                  (cmd_is_data && (int'(cmd_len) > BUF_BYTES));
    cmd_acc     = cmd_valid && cmd_ready;
    push        = cmd_acc && !cmd_bad;
    pop         = (state == S_IDLE) && (cnt != '0);
    cur_is_data = (cur.pid == 3'd1) || (cur.pid == 3'd2);
    tmo_hit     = (tmo == TW'(TIMEOUT_CYC - 1));
  end

  // Queue storage: written on accepted valid commands, never reset
  always_ff @(posedge clk) begin
    if (push) q_mem[wr_ptr] <= '{pid: cmd_pid, len: cmd_len};
  end

  // Queue pointers and occupancy; pointers wrap naturally at QDEPTH
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Next-state logic; fsm_code carries the cause when heading to ERROR
  always_comb begin
    state_n  = state;
    fsm_code = 2'd0;
    case (state)
      S_IDLE:     if (cnt != '0) state_n = S_CHECK;
      S_CHECK: begin
        if (!cur_is_data || (buffer_occupancy >= cur.len)) state_n = S_LAUNCH;
        else if (tmo_hit) begin
          state_n  = S_ERROR;
          fsm_code = 2'd2;
        end
      end
      // launch is held off while the TX core is still busy with something
      S_LAUNCH:   if (!tx_transfer_active) state_n = S_WAIT_ACT;
      S_WAIT_ACT: begin
        if (tx_transfer_active) state_n = S_ACTIVE;
        else if (tmo_hit) begin
          state_n  = S_ERROR;
          fsm_code = 2'd2;
        end
      end
      S_ACTIVE: begin
        if (!tx_transfer_active) begin
          if (txe_flag || tx_error) begin
            state_n  = S_ERROR;
            fsm_code = 2'd3;
          end else begin
            state_n = S_DONE;
          end
        end
      end
      default:    state_n = S_IDLE;
    endcase
  end

  // FSM state, wait-state timer, current command and sticky TX error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      tmo      <= '0;
      cur      <= '0;
      txe_flag <= 1'b0;
    end else begin
      state <= state_n;
      if (state_n != state) tmo <= '0;
      else if ((state == S_CHECK) || (state == S_WAIT_ACT)) tmo <= tmo + 1'b1;
      if (pop) cur <= q_mem[rd_ptr];
      if (state == S_WAIT_ACT) txe_flag <= 1'b0;
      else if ((state == S_ACTIVE) && tx_error) txe_flag <= 1'b1;
    end
  end

  // Error reporting: FSM cause wins over a coincident invalid command
  always_ff @(posedge clk) begin
    if (rst) begin
      inv_q    <= 1'b0;
      err_code <= 2'd0;
    end else begin
      inv_q <= cmd_acc && cmd_bad;
      if (state_n == S_ERROR)   err_code <= fsm_code;
      else if (cmd_acc && cmd_bad) err_code <= 2'd1;
    end
  end

  // Moore-style outputs; tx_start/tx_packet also gate on the TX busy input
  always_comb begin
    cmd_ready  = (cnt != CW'(QDEPTH));
    tx_start   = (state == S_LAUNCH) && !tx_transfer_active;
    tx_packet  = (tx_start || (state == S_WAIT_ACT) || (state == S_ACTIVE)) ?
                 cur.pid : 3'd0;
    flush_req  = (state == S_ERROR) && cur_is_data;
    done_pulse = (state == S_DONE);
    err_pulse  = (state == S_ERROR) || inv_q;
    busy       = (state != S_IDLE) || (cnt != '0);
    q_count    = 3'(cnt);
  end

`ifdef TX_SCHED_STATS_EN
  // Saturating completion / error counters
  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_count <= '0;
      err_count <= '0;
    end else begin
      if (done_pulse && (pkt_count != '1)) pkt_count <= pkt_count + 1'b1;
      if (err_pulse  && (err_count != '1)) err_count <= err_count + 1'b1;
    end
  end
`endif

endmodule
